// File: rtl/fetch_queue.sv
// Instruction-fetch stage: owns the fetch PC, issues requests to a
// variable-latency instruction memory over req/ack, buffers returned words
// (tagged with their PC) in a small FIFO and presents the oldest word to the
// data path.
//
// Handshakes:
//   imem_req/imem_ack : a request is live while imem_req=1; imem_addr is held
//                       stable until the cycle imem_ack=1, which completes it
//                       (ack may arrive in the same cycle req is first seen).
//   instr_valid/instr_ready : the head entry transfers on a cycle where both
//                       are 1; instruction/instr_pc are stable while valid=0.
module fetch_queue #(
  parameter int              DEPTH    = 4,
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_pc,
  output logic                     imem_req,
  output logic [WIDTH-1:0]         imem_addr,
  input  logic                     imem_ack,
  input  logic [WIDTH-1:0]         imem_rdata,
  output logic                     instr_valid,
  output logic [WIDTH-1:0]         instruction,
  output logic [WIDTH-1:0]         instr_pc,
  input  logic                     instr_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]    FULL     = CW'(DEPTH);
  localparam logic [WIDTH-1:0] ALIGN_M  = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] RESET_AL = RESET_PC & ALIGN_M;

  // IDLE: no request; REQ: fetching at fetch_pc; DISCARD: waiting out a
  // request made stale by a redirect before fetching the latched target.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] data_mem_q [DEPTH];
  logic [WIDTH-1:0] data_mem_d [DEPTH];
  logic [WIDTH-1:0] pc_mem_q   [DEPTH];
  logic [WIDTH-1:0] pc_mem_d   [DEPTH];

  logic             push;
  logic             pop;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] redirect_al;

  assign redirect_al = redirect_pc & ALIGN_M;

  // Outputs come straight from registered state; the head is read combinationally.
  assign imem_req    = (state_q != S_IDLE);
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign instruction = data_mem_q[rd_ptr_q];
  assign instr_pc    = pc_mem_q[rd_ptr_q];
  assign count       = count_q;

  // Next-state logic for the fetch FSM, PC, and FIFO bookkeeping.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    data_mem_d = data_mem_q;
    pc_mem_d   = pc_mem_q;

    // A redirect flushes the queue, so any same-cycle push or pop is moot.
    push      = (state_q == S_REQ) && imem_ack && !redirect;
    pop       = instr_valid && instr_ready && !redirect;
    count_nxt = count_q + CW'(push) - CW'(pop);

    case (state_q)
      S_IDLE: begin
        if (redirect) begin
          fetch_pc_d = redirect_al;
          state_d    = S_REQ;
        end else if (count_nxt < FULL) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          if (imem_ack) begin
            // The in-flight word returned this cycle; drop it and restart now.
            fetch_pc_d = redirect_al;
          end else begin
            // The request cannot be withdrawn; wait for its ack first.
            target_d = redirect_al;
            state_d  = S_DISCARD;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + WIDTH'(4);
          state_d    = (count_nxt < FULL) ? S_REQ : S_IDLE;
        end
      end
      S_DISCARD: begin
        if (redirect) begin
          target_d = redirect_al;
        end
        if (imem_ack) begin
          fetch_pc_d = redirect ? redirect_al : target_q;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (push) begin
      data_mem_d[wr_ptr_q] = imem_rdata;
      pc_mem_d[wr_ptr_q]   = fetch_pc_q;
    end

    // On flush the write pointer snaps to the read pointer so the held head
    // output does not move until a new word arrives.
    rd_ptr_d = rd_ptr_q + PW'(pop);
    if (redirect) begin
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_nxt;
    end
  end

  // State registers with synchronous reset; ack during reset has no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_AL;
      target_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      data_mem_q <= data_mem_d;
      pc_mem_q   <= pc_mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a small instruction-memory model with
// programmable ack latency, then a linear sequence of fetch scenarios.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic [2:0]  count;

  // Memory model controls
  logic        mem_en;
  int          mem_lat;
  int          wait_cnt;
  logic        ack_force;

  int n_cmp;
  int n_err;

  fetch_queue #(.DEPTH(4), .WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready),
    .count       (count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: ack after mem_lat waiting cycles of a live request; data is a
  // fixed function of the address so expectations are easy to compute.
  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_ack   = ack_force | (mem_en & imem_req & (wait_cnt >= mem_lat));
  assign imem_rdata = data_of(imem_addr);

  always @(posedge clk) begin
    if (rst || !imem_req || imem_ack) wait_cnt <= 0;
    else                              wait_cnt <= wait_cnt + 1;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    mem_en = 1'b0; mem_lat = 0; ack_force = 1'b0;

    // ---- Reset state ----
    do_reset();
    chk("rst_req",   {31'b0, imem_req}, 32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_count", {29'b0, count}, 32'h0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_ipc",   instr_pc, 32'h0);

    // ---- 1: zero-wait streaming, ready=1 ----
    mem_en = 1'b1; mem_lat = 0; instr_ready = 1'b1;
    tick();
    chk("t1_req",    {31'b0, imem_req}, 32'h1);
    chk("t1_addr0",  imem_addr, 32'h0);
    chk("t1_nvalid", {31'b0, instr_valid}, 32'h0);
    tick();
    chk("t1_addr4",  imem_addr, 32'h4);
    chk("t1_valid",  {31'b0, instr_valid}, 32'h1);
    chk("t1_ipc0",   instr_pc, 32'h0);
    chk("t1_data0",  instruction, data_of(32'h0));
    tick();
    chk("t1_ipc4",   instr_pc, 32'h4);
    chk("t1_data4",  instruction, data_of(32'h4));
    chk("t1_cnt",    {29'b0, count}, 32'h1);
    tick();
    chk("t1_ipc8",   instr_pc, 32'h8);
    chk("t1_addrC",  imem_addr, 32'hC);

    // ---- 2: fill to DEPTH with ready=0, then one pop ----
    instr_ready = 1'b0;
    do_reset();
    tick(); tick(); tick(); tick(); tick();
    chk("t2_full",   {29'b0, count}, 32'h4);
    chk("t2_noreq",  {31'b0, imem_req}, 32'h0);
    chk("t2_addr",   imem_addr, 32'h10);
    tick();
    chk("t2_hold",   {29'b0, count}, 32'h4);
    chk("t2_idle",   {31'b0, imem_req}, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("t2_cnt3",   {29'b0, count}, 32'h3);
    chk("t2_requp",  {31'b0, imem_req}, 32'h1);
    chk("t2_addr10", imem_addr, 32'h10);
    chk("t2_head",   instr_pc, 32'h4);

    // ---- 3: 2-cycle ack latency, redirect while request pending ----
    instr_ready = 1'b1;
    do_reset();
    mem_lat = 2;
    repeat (7) tick();
    chk("t3_addr8",  imem_addr, 32'h8);
    chk("t3_cnt1",   {29'b0, count}, 32'h1);
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    chk("t3_dreq",   {31'b0, imem_req}, 32'h1);
    chk("t3_dhold",  imem_addr, 32'h8);
    chk("t3_flush",  {29'b0, count}, 32'h0);
    chk("t3_dnval",  {31'b0, instr_valid}, 32'h0);
    tick();
    chk("t3_dhold2", imem_addr, 32'h8);
    tick();
    chk("t3_tgt",    imem_addr, 32'h100);
    chk("t3_dropped",{29'b0, count}, 32'h0);
    tick(); tick(); tick();
    chk("t3_valid",  {31'b0, instr_valid}, 32'h1);
    chk("t3_ipc",    instr_pc, 32'h100);
    chk("t3_data",   instruction, data_of(32'h100));

    // ---- 4: redirect with ack and pop in the same cycle, FIFO holding 3 ----
    instr_ready = 1'b0;
    do_reset();
    mem_lat = 0;
    tick(); tick(); tick(); tick();
    chk("t4_cnt3",   {29'b0, count}, 32'h3);
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    chk("t4_cnt0",   {29'b0, count}, 32'h0);
    chk("t4_nvalid", {31'b0, instr_valid}, 32'h0);
    chk("t4_req",    {31'b0, imem_req}, 32'h1);
    chk("t4_addr",   imem_addr, 32'h200);
    tick();
    chk("t4_ipc",    instr_pc, 32'h200);
    chk("t4_cnt1",   {29'b0, count}, 32'h1);

    // ---- 5: reset during DISCARD, late ack ignored ----
    do_reset();
    mem_lat = 2;
    tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("t5_disc",   imem_addr, 32'h0);
    rst = 1'b1; ack_force = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_noreq",  {31'b0, imem_req}, 32'h0);
    chk("t5_addr",   imem_addr, 32'h0);
    chk("t5_cnt",    {29'b0, count}, 32'h0);
    tick();
    ack_force = 1'b0;
    chk("t5_late",   {29'b0, count}, 32'h0);
    chk("t5_req",    {31'b0, imem_req}, 32'h1);
    chk("t5_raddr",  imem_addr, 32'h0);

    // ---- 6: fetch PC wrap ----
    do_reset();
    mem_lat = 0; instr_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("t6_top",    imem_addr, 32'hFFFF_FFFC);
    chk("t6_cnt0",   {29'b0, count}, 32'h0);
    tick();
    chk("t6_wrap",   imem_addr, 32'h0);
    chk("t6_ipc",    instr_pc, 32'hFFFF_FFFC);
    tick();
    chk("t6_ipc0",   instr_pc, 32'h0);
    chk("t6_addr4",  imem_addr, 32'h4);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
